// File: rtl/weight_loader_param_2_pkg.sv
// weight_loader_param_2_pkg: shared weight-RAM geometry defaults and sizing helper for the weight loader
`ifndef NUM_ONEMULT
`define NUM_ONEMULT 4
`endif
`ifndef NUM_ONE_PIXEL_CYCLE
`define NUM_ONE_PIXEL_CYCLE 13
`endif
`ifndef WEIGHT_ADDR_WIDTH
`define WEIGHT_ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package weight_loader_param_2_pkg;
    localparam int DEF_NUM_ONEMULT         = `NUM_ONEMULT;
    localparam int DEF_NUM_ONE_PIXEL_CYCLE = `NUM_ONE_PIXEL_CYCLE;
    localparam int DEF_WEIGHT_ADDR_WIDTH   = `WEIGHT_ADDR_WIDTH;
    localparam int DEF_DATA_WIDTH          = `DATA_WIDTH;

    function automatic int total_pairs(input int groups, input int pairs_per_group);
        return groups * pairs_per_group;
    endfunction
endpackage

// File: rtl/weight_loader_param_2.sv
// weight_loader_param_2: packs a valid/ready word stream into even/odd pairs written to the dual-port weight RAM
module weight_loader_param_2
    import weight_loader_param_2_pkg::*;
#(
    parameter int NUM_ONEMULT         = DEF_NUM_ONEMULT,
    parameter int NUM_ONE_PIXEL_CYCLE = DEF_NUM_ONE_PIXEL_CYCLE,
    parameter int WEIGHT_ADDR_WIDTH   = DEF_WEIGHT_ADDR_WIDTH,
    parameter int DATA_WIDTH          = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         wea,
    output logic                         web,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0]        dina,
    output logic [DATA_WIDTH-1:0]        dinb,
    output logic                         busy,
    output logic                         done
);
    localparam int TOTAL_PAIRS = total_pairs(NUM_ONEMULT, NUM_ONE_PIXEL_CYCLE);
    localparam int PW = $clog2(TOTAL_PAIRS);

    typedef enum logic [1:0] {IDLE, LOAD_EVEN, LOAD_ODD, DONE} state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  pair_idx_q, pair_idx_d;
    logic [DATA_WIDTH-1:0]          hold_q, hold_d, dina_q, dina_d, dinb_q, dinb_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   addra_q, addra_d, addrb_q, addrb_d;
    logic                           wea_q, wea_d, done_q, done_d;
    logic                           xfer;

    assign in_ready = state_q == LOAD_EVEN || state_q == LOAD_ODD;
    assign busy     = in_ready;
    assign xfer     = in_valid && in_ready;
    assign wea      = wea_q;
    assign web      = wea_q;
    assign addra    = addra_q;
    assign addrb    = addrb_q;
    assign dina     = dina_q;
    assign dinb     = dinb_q;
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        pair_idx_d = pair_idx_q;
        hold_d     = hold_q;
        addra_d    = addra_q;
        addrb_d    = addrb_q;
        dina_d     = dina_q;
        dinb_d     = dinb_q;
        wea_d      = 1'b0;
        // done follows DONE by one cycle so the last pair has committed to RAM first
        done_d     = state_q == DONE && !start;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD_EVEN;
                    pair_idx_d = '0;
                end
            end
            LOAD_EVEN: begin
                if (xfer) begin
                    hold_d  = in_data;
                    state_d = LOAD_ODD;
                end
            end
            LOAD_ODD: begin
                if (xfer) begin
                    wea_d      = 1'b1;
                    addra_d    = WEIGHT_ADDR_WIDTH'({pair_idx_q, 1'b0});
                    addrb_d    = WEIGHT_ADDR_WIDTH'({pair_idx_q, 1'b1});
                    dina_d     = hold_q;
                    dinb_d     = in_data;
                    state_d    = pair_idx_q == PW'(TOTAL_PAIRS - 1) ? DONE : LOAD_EVEN;
                    pair_idx_d = pair_idx_q == PW'(TOTAL_PAIRS - 1) ? pair_idx_q : pair_idx_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pair_idx_q <= '0;
            hold_q     <= '0;
            addra_q    <= '0;
            addrb_q    <= WEIGHT_ADDR_WIDTH'(1);
            dina_q     <= '0;
            dinb_q     <= '0;
            wea_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pair_idx_q <= pair_idx_d;
            hold_q     <= hold_d;
            addra_q    <= addra_d;
            addrb_q    <= addrb_d;
            dina_q     <= dina_d;
            dinb_q     <= dinb_d;
            wea_q      <= wea_d;
            done_q     <= done_d;
        end
    end
endmodule
